// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : note_pkg
// Brief   : Shared constants for the note sequencer: lane codes, chart entry
//           field positions, terminator value and FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package note_pkg;

    localparam int ENTRY_W = 10;
    localparam int STEP_W  = 6;
    localparam int COUNT_W = 8;

    // Lane codes driven on key_address
    localparam logic [1:0] LANE_REST = 2'b00;
    localparam logic [1:0] LANE_DO   = 2'b01;
    localparam logic [1:0] LANE_RE   = 2'b10;
    localparam logic [1:0] LANE_MI   = 2'b11;

    // Chart entry field positions: [9:8] lane, [7:4] hold, [3:0] gap
    localparam int LANE_MSB = 9;
    localparam int LANE_LSB = 8;
    localparam int HOLD_MSB = 7;
    localparam int HOLD_LSB = 4;
    localparam int GAP_MSB  = 3;
    localparam int GAP_LSB  = 0;

    localparam logic [ENTRY_W-1:0] ENTRY_TERMINATOR = '0;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_NOTE  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Packs a chart entry from its three fields
    function automatic logic [ENTRY_W-1:0] make_entry(input logic [1:0] lane,
                                                      input logic [3:0] hold,
                                                      input logic [3:0] gap);
        return {lane, hold, gap};
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : note_sequencer_if
// Brief   : Control/display bundle between game control, the note sequencer
//           and the lane display calculator.
// Revision: 1.0 - initial release
// ============================================================================
interface note_sequencer_if;

    logic       tick;
    logic       start;
    logic       pause;
    logic       wren;
    logic [1:0] key_address;
    logic [5:0] step;
    logic       busy;
    logic       song_done;

    // Game-control side: drives timing and keys, observes the sequencer
    modport master (
        output tick, start, pause,
        input  wren, key_address, step, busy, song_done
    );

    // Sequencer side
    modport slave (
        input  tick, start, pause,
        output wren, key_address, step, busy, song_done
    );

endinterface
`default_nettype wire

// File: rtl/note_sequencer_chart_rom.sv
`default_nettype none
// ============================================================================
// Module  : note_chart_rom
// Brief   : Combinational song chart, step index -> 10-bit chart entry.
//           A replacement chart can be supplied through TEST_CHART.
// Revision: 1.0 - initial release
// ============================================================================
module note_chart_rom
    import note_pkg::*;
#(
    parameter int                          CHART_DEPTH    = 64,
    parameter bit                          USE_TEST_CHART = 1'b0,
    parameter logic [CHART_DEPTH*ENTRY_W-1:0] TEST_CHART  = '0
)(
    input  wire logic [STEP_W-1:0]  i_addr,
    output logic      [ENTRY_W-1:0] o_entry
);

    if (USE_TEST_CHART) begin : g_test_chart
        // Externally supplied chart, entry n at bits [n*10 +: 10]
        always_comb begin
            o_entry = TEST_CHART[i_addr*ENTRY_W +: ENTRY_W];
        end
    end else begin : g_song_chart
        // Built-in song table; everything past the last note is a terminator
        always_comb begin
            o_entry = ENTRY_TERMINATOR;
            case (i_addr)
                6'd0:  o_entry = make_entry(LANE_MI, 4'd8, 4'd2);
                6'd1:  o_entry = make_entry(LANE_MI, 4'd8, 4'd2);
                6'd2:  o_entry = make_entry(LANE_RE, 4'd8, 4'd2);
                6'd3:  o_entry = make_entry(LANE_DO, 4'd8, 4'd2);
                6'd4:  o_entry = make_entry(LANE_DO, 4'd8, 4'd2);
                6'd5:  o_entry = make_entry(LANE_RE, 4'd8, 4'd2);
                6'd6:  o_entry = make_entry(LANE_MI, 4'd12, 4'd0);
                6'd7:  o_entry = make_entry(LANE_RE, 4'd4, 4'd2);
                6'd8:  o_entry = make_entry(LANE_RE, 4'd15, 4'd6);
                6'd9:  o_entry = make_entry(LANE_MI, 4'd8, 4'd2);
                6'd10: o_entry = make_entry(LANE_RE, 4'd8, 4'd2);
                6'd11: o_entry = make_entry(LANE_DO, 4'd15, 4'd8);
                default: o_entry = ENTRY_TERMINATOR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : note_sequencer
// Brief   : Steps through the song chart on the scroll tick, emitting lane
//           codes (note hold, rest gap) and a final drain of rest ticks.
// Revision: 1.0 - initial release
// ============================================================================
module note_sequencer
    import note_pkg::*;
#(
    parameter int                             CHART_DEPTH    = 64,
    parameter int                             DRAIN_TICKS    = 120,
    parameter bit                             USE_TEST_CHART = 1'b0,
    parameter logic [CHART_DEPTH*ENTRY_W-1:0] TEST_CHART     = '0
)(
    input  wire logic       clock,
    input  wire logic       resetn,
    note_sequencer_if.slave bus
);

    logic [2:0]         r_state;
    logic [COUNT_W-1:0] r_count;
    logic [STEP_W-1:0]  r_step;
    logic [1:0]         r_key;
    logic               r_wren;

    logic [ENTRY_W-1:0] w_entry;
    logic [1:0]         w_lane;
    logic [3:0]         w_hold;
    logic [3:0]         w_gap;
    logic               w_tick;
    logic               w_last;
    logic               w_expire;

    note_chart_rom #(
        .CHART_DEPTH    (CHART_DEPTH),
        .USE_TEST_CHART (USE_TEST_CHART),
        .TEST_CHART     (TEST_CHART)
    ) u_chart_rom (
        .i_addr  (r_step),
        .o_entry (w_entry)
    );

    // Step is stable through NOTE/GAP, so the ROM output is the live entry
    assign w_lane   = w_entry[LANE_MSB:LANE_LSB];
    assign w_hold   = (w_entry[HOLD_MSB:HOLD_LSB] == 4'd0) ? 4'd1 : w_entry[HOLD_MSB:HOLD_LSB];
    assign w_gap    = w_entry[GAP_MSB:GAP_LSB];
    assign w_tick   = bus.tick & ~bus.pause;
    assign w_last   = (r_step == STEP_W'(CHART_DEPTH - 1));
    assign w_expire = w_tick && (r_count == COUNT_W'(1));

    // Sequencer FSM with registered display outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_step  <= '0;
            r_key   <= LANE_REST;
            r_wren  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_step  <= '0;
                        r_wren  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // key_address holds through LOAD so back-to-back notes do not blink
                    if (w_entry == ENTRY_TERMINATOR) begin
                        r_count <= COUNT_W'(DRAIN_TICKS);
                        r_key   <= LANE_REST;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_count <= COUNT_W'(w_hold);
                        r_key   <= w_lane;
                        r_state <= ST_NOTE;
                    end
                end
                ST_NOTE, ST_GAP: begin
                    if (w_expire) begin
                        if (r_state == ST_NOTE && w_gap != 4'd0) begin
                            r_count <= COUNT_W'(w_gap);
                            r_key   <= LANE_REST;
                            r_state <= ST_GAP;
                        end else if (w_last) begin
                            r_count <= COUNT_W'(DRAIN_TICKS);
                            r_key   <= LANE_REST;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_step  <= r_step + STEP_W'(1);
                            r_state <= ST_LOAD;
                        end
                    end else if (w_tick) begin
                        r_count <= r_count - COUNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_expire) begin
                        r_key   <= LANE_REST;
                        r_wren  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_tick) begin
                        r_count <= r_count - COUNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_key   <= LANE_REST;
                    r_wren  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.wren        = r_wren;
    assign bus.key_address = r_key;
    assign bus.step        = r_step;
    assign bus.busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.song_done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_note_sequencer
// Brief   : Self-checking bench: two sequencers (terminated chart, full chart)
//           share stimulus and are compared every cycle to a segment model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_note_sequencer;
    import note_pkg::*;

    localparam int DRAIN = 120;
    localparam int MAXSEG = 160;

    // Chart A: do(3)+gap2, re(hold0->1), mi(2), rest-note(2)+gap1, terminator
    function automatic logic [639:0] build_chart_a();
        logic [639:0] c;
        c = '0;
        c[0*10 +: 10] = make_entry(2'b01, 4'd3, 4'd2);
        c[1*10 +: 10] = make_entry(2'b10, 4'd0, 4'd0);
        c[2*10 +: 10] = make_entry(2'b11, 4'd2, 4'd0);
        c[3*10 +: 10] = make_entry(2'b00, 4'd2, 4'd1);
        return c;
    endfunction

    // Chart B: 64 non-terminator entries
    function automatic logic [639:0] build_chart_b();
        logic [639:0] c;
        logic [3:0]   gap;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            gap = (i % 4 == 1) ? 4'd0 : 4'(1 + i % 2);
            c[i*10 +: 10] = make_entry(2'(i % 4), 4'(i % 3), gap);
        end
        return c;
    endfunction

    localparam logic [639:0] CHART_A = build_chart_a();
    localparam logic [639:0] CHART_B = build_chart_b();

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic cmp_en = 1'b0;
    int   n_checks = 0, n_errors = 0;

    always #5 clock = ~clock;

    note_sequencer_if ifa();
    note_sequencer_if ifb();
    assign ifa.tick = tick;  assign ifa.start = start;  assign ifa.pause = pause;
    assign ifb.tick = tick;  assign ifb.start = start;  assign ifb.pause = pause;

    note_sequencer #(.CHART_DEPTH(64), .DRAIN_TICKS(DRAIN), .USE_TEST_CHART(1'b1), .TEST_CHART(CHART_A))
        u_dut_a (.clock(clock), .resetn(resetn), .bus(ifa));
    note_sequencer #(.CHART_DEPTH(64), .DRAIN_TICKS(DRAIN), .USE_TEST_CHART(1'b1), .TEST_CHART(CHART_B))
        u_dut_b (.clock(clock), .resetn(resetn), .bus(ifb));

    // ---------------- behavioural model: song as a list of timed segments ----
    logic [1:0] seg_lane [2][MAXSEG];
    int         seg_len  [2][MAXSEG];
    int         seg_step [2][MAXSEG];
    bit         seg_load [2][MAXSEG];   // a LOAD cycle precedes this segment
    int         seg_n    [2];

    bit   m_active[2], m_done[2], m_load[2], m_wren[2];
    int   m_idx[2], m_rem[2], m_step[2];
    logic [1:0] m_key[2];

    function automatic logic [9:0] chart_entry(int d, int i);
        return (d == 0) ? CHART_A[i*10 +: 10] : CHART_B[i*10 +: 10];
    endfunction

    task automatic push_seg(int d, logic [1:0] lane, int len, int stp, bit ld);
        seg_lane[d][seg_n[d]] = lane;
        seg_len [d][seg_n[d]] = len;
        seg_step[d][seg_n[d]] = stp;
        seg_load[d][seg_n[d]] = ld;
        seg_n[d]++;
    endtask

    task automatic build_song(int d);
        logic [9:0] e;
        int  last;
        bit  term;
        int  hold;
        seg_n[d] = 0;
        last = 0;
        term = 0;
        for (int i = 0; i < 64; i++) begin
            e = chart_entry(d, i);
            last = i;
            if (e == 10'd0) begin
                term = 1;
                break;
            end
            hold = (e[7:4] == 0) ? 1 : int'(e[7:4]);
            push_seg(d, e[9:8], hold, i, 1'b1);
            if (e[3:0] != 0) push_seg(d, 2'b00, int'(e[3:0]), i, 1'b0);
        end
        // A terminator is read by a LOAD; running off the end is not
        push_seg(d, 2'b00, DRAIN, last, term);
    endtask

    task automatic model_reset(int d);
        m_active[d] = 0; m_done[d] = 0; m_load[d] = 0; m_wren[d] = 1;
        m_idx[d] = 0; m_rem[d] = 0; m_step[d] = 0; m_key[d] = 2'b00;
    endtask

    task automatic model_edge(int d, bit st, bit tk, bit ps);
        if (!m_active[d]) begin
            if (st) begin
                build_song(d);
                m_active[d] = 1; m_done[d] = 0; m_load[d] = 1;
                m_idx[d] = 0; m_step[d] = 0; m_wren[d] = 0;
            end
        end else if (m_load[d]) begin
            m_load[d] = 0;
            m_rem[d]  = seg_len[d][m_idx[d]];
            m_key[d]  = seg_lane[d][m_idx[d]];
        end else if (tk && !ps) begin
            if (m_rem[d] == 1) begin
                m_idx[d]++;
                if (m_idx[d] == seg_n[d]) begin
                    m_active[d] = 0; m_done[d] = 1; m_wren[d] = 1; m_key[d] = 2'b00;
                end else begin
                    m_step[d] = seg_step[d][m_idx[d]];
                    if (seg_load[d][m_idx[d]]) m_load[d] = 1;
                    else begin
                        m_rem[d] = seg_len[d][m_idx[d]];
                        m_key[d] = seg_lane[d][m_idx[d]];
                    end
                end
            end else begin
                m_rem[d]--;
            end
        end
    endtask

    // Model follows the same clock and asynchronous reset as the DUTs
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_edge(0, start, tick, pause);
            model_edge(1, start, tick, pause);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(int d, logic wren, logic [1:0] key, logic [5:0] stp, logic busy, logic done);
        string tag;
        tag = (d == 0) ? "A" : "B";
        chk({tag, ".wren"},        32'(wren), 32'(m_wren[d]));
        chk({tag, ".key_address"}, 32'(key),  32'(m_key[d]));
        chk({tag, ".step"},        32'(stp),  32'(m_step[d]));
        chk({tag, ".busy"},        32'(busy), 32'(m_active[d]));
        chk({tag, ".song_done"},   32'(done), 32'(m_done[d]));
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en && resetn) begin
            cmp_dut(0, ifa.wren, ifa.key_address, ifa.step, ifa.busy, ifa.song_done);
            cmp_dut(1, ifb.wren, ifb.key_address, ifb.step, ifb.busy, ifb.song_done);
        end
    end

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit prev;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        cmp_en = 1'b1;
        @(negedge clock);
        chk("reset.wren", 32'(ifa.wren), 32'd1);
        chk("reset.key",  32'(ifa.key_address), 32'd0);
        chk("reset.busy", 32'(ifa.busy), 32'd0);

        // Start: one LOAD cycle, then the first note
        start = 1'b1; @(negedge clock); start = 1'b0;
        chk("load.busy", 32'(ifa.busy), 32'd1);
        chk("load.wren", 32'(ifa.wren), 32'd0);
        @(negedge clock);
        chk("note0.key", 32'(ifa.key_address), 32'd1);

        // Pause with 2 ticks remaining on the 3-tick note
        pulse_tick();
        pause = 1'b1;
        repeat (50) pulse_tick();
        chk("pause.key", 32'(ifa.key_address), 32'd1);
        pause = 1'b0;
        pulse_tick();
        chk("pause.end-1", 32'(ifa.key_address), 32'd1);
        pulse_tick();
        chk("gap0.key", 32'(ifa.key_address), 32'd0);
        chk("gap0.step", 32'(ifa.step), 32'd0);
        repeat (2) pulse_tick();
        chk("re.key", 32'(ifa.key_address), 32'd2);
        chk("re.step", 32'(ifa.step), 32'd1);
        pulse_tick();
        chk("mi.key", 32'(ifa.key_address), 32'd3);
        chk("mi.step", 32'(ifa.step), 32'd2);
        repeat (2) pulse_tick();
        chk("rest.step", 32'(ifa.step), 32'd3);
        chk("rest.key", 32'(ifa.key_address), 32'd0);

        // Rest note (2), gap (1), drain (120) -> DONE
        for (int i = 0; i < 300 && !ifa.song_done; i++) pulse_tick();
        chk("done.song_done", 32'(ifa.song_done), 32'd1);
        chk("done.wren", 32'(ifa.wren), 32'd1);
        chk("done.step", 32'(ifa.step), 32'd4);

        // Restart from DONE (B is busy and ignores it)
        start = 1'b1; @(negedge clock); start = 1'b0;
        chk("restart.step", 32'(ifa.step), 32'd0);
        chk("restart.busy", 32'(ifa.busy), 32'd1);
        @(negedge clock);
        chk("restart.key", 32'(ifa.key_address), 32'd1);

        // Asynchronous reset mid-note, no clock edge involved
        #2 resetn = 1'b0;
        #1;
        chk("areset.wren", 32'(ifa.wren), 32'd1);
        chk("areset.key",  32'(ifa.key_address), 32'd0);
        chk("areset.step", 32'(ifa.step), 32'd0);
        chk("areset.busy", 32'(ifa.busy), 32'd0);
        chk("areset.busyB", 32'(ifb.busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Randomised tick/pause/start traffic
        prev = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            tick = !prev && ($urandom_range(0, 2) == 0);
            prev = tick;
            if ($urandom_range(0, 29) == 0) pause = !pause;
            start = ($urandom_range(0, 79) == 0);
            @(negedge clock);
        end
        tick = 1'b0; start = 1'b0; pause = 1'b0;
        @(negedge clock);

        // Full chart runs off the end into DRAIN; step stays at the last index
        start = 1'b1; @(negedge clock); start = 1'b0;
        for (int i = 0; i < 1500 && !ifb.song_done; i++) pulse_tick();
        chk("full.song_done", 32'(ifb.song_done), 32'd1);
        chk("full.step", 32'(ifb.step), 32'd63);
        chk("full.wren", 32'(ifb.wren), 32'd1);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
